// File: rtl/muldiv_seq_pkg.sv
// ============================================================================
// Module  : muldiv_seq_pkg
// Brief   : Shared state encoding, hilo_op field indices and width default
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package muldiv_seq_pkg;

   localparam int WIDTH_DEF = 32;

   // Bit positions of the request bits within hilo_op
   localparam int OP_MULT  = 0;
   localparam int OP_MULTU = 1;
   localparam int OP_DIV   = 2;
   localparam int OP_DIVU  = 3;

   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_MUL  = 3'd1;
   localparam logic [2:0] ST_DIV  = 3'd2;
   localparam logic [2:0] ST_DZ   = 3'd3;
   localparam logic [2:0] ST_DONE = 3'd4;

endpackage

`default_nettype wire

// File: rtl/muldiv_step.sv
// ============================================================================
// Module  : muldiv_step
// Brief   : One combinational iteration: restoring-divide step and shift-add
//           multiply step. MULDIV_FAST_MUL_EN removes the shift-add path.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module muldiv_step
   import muldiv_seq_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic [WIDTH-1:0] i_hi,
   input  logic [WIDTH-1:0] i_lo,
   input  logic [WIDTH-1:0] i_opnd,
   output logic [WIDTH-1:0] o_div_hi,
   output logic [WIDTH-1:0] o_div_lo
`ifndef MULDIV_FAST_MUL_EN
   ,
   output logic [WIDTH-1:0] o_mul_hi,
   output logic [WIDTH-1:0] o_mul_lo
`endif
);

   logic [WIDTH:0] w_shift;
   logic [WIDTH:0] w_trial;

   // {rem, quot} shifted left; one extra bit keeps the trial sign visible
   assign w_shift  = {i_hi, i_lo[WIDTH-1]};
   assign w_trial  = w_shift - {1'b0, i_opnd};
   assign o_div_hi = w_trial[WIDTH] ? w_shift[WIDTH-1:0] : w_trial[WIDTH-1:0];
   assign o_div_lo = {i_lo[WIDTH-2:0], ~w_trial[WIDTH]};

`ifndef MULDIV_FAST_MUL_EN
   logic [WIDTH:0] w_sum;

   // Multiplier sits in the low half and is consumed LSB first as product bits enter
   assign w_sum    = {1'b0, i_hi} + (i_lo[0] ? {1'b0, i_opnd} : '0);
   assign o_mul_hi = w_sum[WIDTH:1];
   assign o_mul_lo = {w_sum[0], i_lo[WIDTH-1:1]};
`endif

endmodule

`default_nettype wire

// File: rtl/muldiv_seq.sv
// ============================================================================
// Module  : muldiv_seq
// Brief   : Multi-cycle HI/LO mult/div sequencer with pipeline stall request.
//           Define MULDIV_FAST_MUL_EN for a single-cycle multiply.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module muldiv_seq
   import muldiv_seq_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             op_mult,
   input  logic             op_multu,
   input  logic             op_div,
   input  logic             op_divu,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   input  logic             cancel,
   output logic             stallreq,
   output logic             busy,
   output logic             hi_we,
   output logic             lo_we,
   output logic [WIDTH-1:0] hi_o,
   output logic [WIDTH-1:0] lo_o
);

   localparam logic [CNT_W-1:0] c_last = CNT_W'(WIDTH - 1);

   logic [2:0]       r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [WIDTH-1:0] r_acc_hi, r_acc_lo, r_opnd, r_hi, r_lo;
   logic             r_neg_hi, r_neg_lo, r_we;

   logic [3:0]       w_ops;
   logic             w_start, w_is_div, w_signed, w_neg_ab;
   logic [WIDTH-1:0] w_abs_a, w_abs_b;
   logic [WIDTH-1:0] w_div_hi, w_div_lo, w_div_hi_c, w_div_lo_c;

   always_comb begin
      w_ops           = '0;
      w_ops[OP_MULT]  = op_mult;
      w_ops[OP_MULTU] = op_multu;
      w_ops[OP_DIV]   = op_div;
      w_ops[OP_DIVU]  = op_divu;
   end

   // Priority div > divu > mult > multu decides signedness when bits overlap
   assign w_start  = |w_ops;
   assign w_is_div = w_ops[OP_DIV] | w_ops[OP_DIVU];
   assign w_signed = w_ops[OP_DIV] | (~w_ops[OP_DIVU] & w_ops[OP_MULT]);
   assign w_neg_ab = w_signed & (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
   assign w_abs_a  = (w_signed & src_a[WIDTH-1]) ? -src_a : src_a;
   assign w_abs_b  = (w_signed & src_b[WIDTH-1]) ? -src_b : src_b;

   assign w_div_hi_c = r_neg_hi ? -w_div_hi : w_div_hi;
   assign w_div_lo_c = r_neg_lo ? -w_div_lo : w_div_lo;

`ifdef MULDIV_FAST_MUL_EN
   logic [2*WIDTH-1:0] w_fast_prod, w_fast_res;

   assign w_fast_prod = {{WIDTH{1'b0}}, w_abs_a} * {{WIDTH{1'b0}}, w_abs_b};
   assign w_fast_res  = w_neg_ab ? -w_fast_prod : w_fast_prod;

   muldiv_step #(.WIDTH(WIDTH)) u_step (
      .i_hi     (r_acc_hi),
      .i_lo     (r_acc_lo),
      .i_opnd   (r_opnd),
      .o_div_hi (w_div_hi),
      .o_div_lo (w_div_lo)
   );
`else
   logic [WIDTH-1:0]   w_mul_hi, w_mul_lo;
   logic [2*WIDTH-1:0] w_mul_prod, w_mul_res;

   assign w_mul_prod = {w_mul_hi, w_mul_lo};
   assign w_mul_res  = r_neg_lo ? -w_mul_prod : w_mul_prod;

   muldiv_step #(.WIDTH(WIDTH)) u_step (
      .i_hi     (r_acc_hi),
      .i_lo     (r_acc_lo),
      .i_opnd   (r_opnd),
      .o_div_hi (w_div_hi),
      .o_div_lo (w_div_lo),
      .o_mul_hi (w_mul_hi),
      .o_mul_lo (w_mul_lo)
   );
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= ST_IDLE;
         r_cnt    <= '0;
         r_acc_hi <= '0;
         r_acc_lo <= '0;
         r_opnd   <= '0;
         r_hi     <= '0;
         r_lo     <= '0;
         r_neg_hi <= 1'b0;
         r_neg_lo <= 1'b0;
         r_we     <= 1'b0;
      end else begin
         r_we <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_start && !cancel) begin
                  r_cnt <= '0;
                  if (w_is_div) begin
                     if (src_b == '0) begin
                        r_state  <= ST_DZ;
                        r_acc_hi <= src_a;
                        r_acc_lo <= '1;
                        r_neg_hi <= 1'b0;
                        r_neg_lo <= 1'b0;
                     end else begin
                        r_state  <= ST_DIV;
                        r_acc_hi <= '0;
                        r_acc_lo <= w_abs_a;
                        r_opnd   <= w_abs_b;
                        r_neg_hi <= w_signed & src_a[WIDTH-1];
                        r_neg_lo <= w_neg_ab;
                     end
                  end else begin
`ifdef MULDIV_FAST_MUL_EN
                     r_state <= ST_DONE;
                     r_we    <= 1'b1;
                     r_hi    <= w_fast_res[2*WIDTH-1:WIDTH];
                     r_lo    <= w_fast_res[WIDTH-1:0];
`else
                     r_state  <= ST_MUL;
                     r_acc_hi <= '0;
                     r_acc_lo <= w_abs_b;
                     r_opnd   <= w_abs_a;
                     r_neg_hi <= 1'b0;
                     r_neg_lo <= w_neg_ab;
`endif
                  end
               end
            end
`ifndef MULDIV_FAST_MUL_EN
            ST_MUL: begin
               if (cancel) begin
                  r_state <= ST_IDLE;
               end else begin
                  r_acc_hi <= w_mul_hi;
                  r_acc_lo <= w_mul_lo;
                  r_cnt    <= r_cnt + 1'b1;
                  if (r_cnt == c_last) begin
                     r_state <= ST_DONE;
                     r_we    <= 1'b1;
                     r_hi    <= w_mul_res[2*WIDTH-1:WIDTH];
                     r_lo    <= w_mul_res[WIDTH-1:0];
                  end
               end
            end
`endif
            ST_DIV: begin
               if (cancel) begin
                  r_state <= ST_IDLE;
               end else begin
                  r_acc_hi <= w_div_hi;
                  r_acc_lo <= w_div_lo;
                  r_cnt    <= r_cnt + 1'b1;
                  if (r_cnt == c_last) begin
                     r_state <= ST_DONE;
                     r_we    <= 1'b1;
                     r_hi    <= w_div_hi_c;
                     r_lo    <= w_div_lo_c;
                  end
               end
            end
            ST_DZ: begin
               if (cancel) begin
                  r_state <= ST_IDLE;
               end else begin
                  r_state <= ST_DONE;
                  r_we    <= 1'b1;
                  r_hi    <= r_acc_hi;
                  r_lo    <= r_acc_lo;
               end
            end
            // Result already committed; the same instruction is still in EX
            ST_DONE: r_state <= ST_IDLE;
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign stallreq = ((r_state == ST_IDLE) & w_start & ~cancel) |
                     (r_state == ST_MUL) | (r_state == ST_DIV) | (r_state == ST_DZ);
   assign busy  = (r_state != ST_IDLE);
   assign hi_we = r_we;
   assign lo_we = r_we;
   assign hi_o  = r_hi;
   assign lo_o  = r_lo;

endmodule

`default_nettype wire
